axis_gen32_checker: RTL and testbench

AXIS_GEN32_CHECKER -- requirements
Module: axis_gen32_checker

---
 rtl/axis_gen32_checker.sv | 138 +++++++++++++
 tb/tb_axis_gen32_checker.sv | 375 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_gen32_checker.sv
// Pass-through checker for the 32-bit AXI-Stream frame generator: forwards beats through one
// register slice and verifies the 0xAAAAAA/index pattern. Define AXIS_GEN32_CHECKER_FIRST_ERR_EN to capture the first bad beat.
module axis_gen32_checker #(
  parameter int BYTES_PER_BLOCK = 64
) (
  input  logic        aclk,
  input  logic        areset,
  input  logic [31:0] s_tdata,
  input  logic        s_tvalid,
  output logic        s_tready,
  input  logic        s_tlast,
  input  logic [3:0]  s_tkeep,
  output logic [31:0] m_tdata,
  output logic        m_tvalid,
  input  logic        m_tready,
  output logic        m_tlast,
  output logic [3:0]  m_tkeep,
  input  logic        clr,
  output logic [31:0] frame_cnt,
  output logic [31:0] err_cnt,
  output logic        err,
  output logic        lost,
  output logic [31:0] first_err_data,
  output logic [7:0]  first_err_idx
);
  localparam int         WORDS    = BYTES_PER_BLOCK / 4;
  localparam logic [7:0] LAST_IDX = 8'(WORDS - 1);

  // Handshake: a beat moves on a port in a cycle where tvalid and tready are both high at the
  // rising edge; tvalid never waits on tready, and a held beat stays stable until it moves.
  typedef enum logic {RUN = 1'b0, LOST = 1'b1} state_t;

  state_t     state, state_nxt;
  logic [7:0] idx;
  logic       frame_ok;
  logic       acc, at_last, bad, frame_done;

  assign s_tready = !m_tvalid || m_tready;
  assign acc      = s_tvalid && s_tready;
  assign at_last  = (idx == LAST_IDX);

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      m_tvalid <= 1'b0;
      m_tdata  <= '0;
      m_tlast  <= 1'b0;
      m_tkeep  <= '0;
    end else if (acc) begin
      m_tvalid <= 1'b1;
      m_tdata  <= s_tdata;
      m_tlast  <= s_tlast;
      m_tkeep  <= s_tkeep;
    end else if (m_tready) begin
      m_tvalid <= 1'b0;
    end
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) state <= RUN;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (acc) begin
      case (state)
        RUN:     if (!s_tlast && at_last) state_nxt = LOST;
        LOST:    if (s_tlast) state_nxt = RUN;
        default: state_nxt = RUN;
      endcase
    end
  end

  always_comb begin
    lost       = (state == LOST);
    bad        = 1'b0;
    frame_done = 1'b0;
    if (acc && state == RUN) begin
      bad = (s_tdata[31:8] != 24'hAAAAAA) || (s_tdata[7:0] != idx) ||
            (s_tkeep != 4'hF) || (s_tlast != at_last);
      frame_done = s_tlast && frame_ok && !bad;
    end
  end

  // A frame boundary (tlast, or a missed tlast that drops sync) restarts both index and frame health.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      idx      <= '0;
      frame_ok <= 1'b1;
    end else if (acc) begin
      if (s_tlast || (state == RUN && at_last)) begin
        idx      <= '0;
        frame_ok <= 1'b1;
      end else begin
        idx <= idx + 8'd1;
        if (bad) frame_ok <= 1'b0;
      end
    end
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      frame_cnt <= '0;
      err_cnt   <= '0;
      err       <= 1'b0;
    end else if (clr) begin
      frame_cnt <= '0;
      err_cnt   <= '0;
      err       <= 1'b0;
    end else begin
      if (frame_done) frame_cnt <= frame_cnt + 32'd1;
      if (bad) begin
        if (err_cnt != 32'hFFFFFFFF) err_cnt <= err_cnt + 32'd1;
        err <= 1'b1;
      end
    end
  end

`ifdef AXIS_GEN32_CHECKER_FIRST_ERR_EN
  // err still low in the cycle of a bad beat marks it as the first since reset/clr.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      first_err_data <= '0;
      first_err_idx  <= '0;
    end else if (clr) begin
      first_err_data <= '0;
      first_err_idx  <= '0;
    end else if (bad && !err) begin
      first_err_data <= s_tdata;
      first_err_idx  <= idx;
    end
  end
`else
  assign first_err_data = '0;
  assign first_err_idx  = '0;
`endif

endmodule

// File: tb/tb_axis_gen32_checker.sv
// Self-checking bench for axis_gen32_checker: randomized traffic and backpressure against a
// frame-level reference model and an expected-beat queue.
module tb_axis_gen32_checker;
  localparam int BYTES_PER_BLOCK = 64;
  localparam int WORDS = BYTES_PER_BLOCK / 4;
`ifdef AXIS_GEN32_CHECKER_FIRST_ERR_EN
  localparam bit FE_EN = 1'b1;
`else
  localparam bit FE_EN = 1'b0;
`endif

  // clock / reset
  logic aclk = 1'b0;
  logic areset = 1'b1;
  always #5 aclk = ~aclk;

  logic [31:0] s_tdata = '0;
  logic        s_tvalid = 1'b0, s_tlast = 1'b0;
  logic [3:0]  s_tkeep = '0;
  logic        s_tready;
  logic [31:0] m_tdata;
  logic        m_tvalid, m_tlast;
  logic [3:0]  m_tkeep;
  logic        m_tready = 1'b1;
  logic        clr = 1'b0;
  logic [31:0] frame_cnt, err_cnt, first_err_data;
  logic        err, lost;
  logic [7:0]  first_err_idx;

  int checks = 0;
  int errors = 0;
  int ready_mode = 0;  // 0 always ready, 1 toggle, 2 random, 3 stalled
  bit tog = 1'b0;

  logic [36:0] exp_q[$];  // {tdata, tlast, tkeep} of beats accepted but not yet delivered

  // reference model, in terms of frames and positions within them
  int          md_pos;
  bit          md_synced, md_clean, md_err;
  logic [31:0] md_frame_cnt, md_err_cnt, md_fed;
  logic [7:0]  md_fei;

  axis_gen32_checker #(.BYTES_PER_BLOCK(BYTES_PER_BLOCK)) dut (
    .aclk(aclk), .areset(areset),
    .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tlast(s_tlast), .s_tkeep(s_tkeep),
    .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tlast(m_tlast), .m_tkeep(m_tkeep),
    .clr(clr), .frame_cnt(frame_cnt), .err_cnt(err_cnt), .err(err), .lost(lost),
    .first_err_data(first_err_data), .first_err_idx(first_err_idx)
  );

  function automatic void model_clear();
    md_frame_cnt = '0; md_err_cnt = '0; md_err = 1'b0; md_fed = '0; md_fei = '0;
  endfunction

  function automatic void model_reset();
    md_pos = 0; md_synced = 1'b1; md_clean = 1'b1;
    model_clear();
  endfunction

  function automatic void model_accept(input logic [31:0] d, input logic l, input logic [3:0] k);
    bit bad;
    if (md_synced) begin
      bad = (d[31:8] != 24'hAAAAAA) || (int'(d[7:0]) != md_pos) || (k != 4'hF) ||
            (l != (md_pos == WORDS - 1));
      if (bad) begin
        if (md_err_cnt != 32'hFFFFFFFF) md_err_cnt = md_err_cnt + 1;
        if (!md_err) begin md_fed = d; md_fei = 8'(md_pos); end
        md_err = 1'b1;
        md_clean = 1'b0;
      end
      if (l) begin
        if (md_clean) md_frame_cnt = md_frame_cnt + 1;
        md_clean = 1'b1;
        md_pos = 0;
      end else if (md_pos == WORDS - 1) begin
        md_synced = 1'b0;
        md_clean = 1'b1;
        md_pos = 0;
      end else begin
        md_pos++;
      end
    end else if (l) begin
      md_synced = 1'b1;
      md_clean = 1'b1;
      md_pos = 0;
    end else begin
      md_pos = (md_pos + 1) % 256;
    end
  endfunction

  // scoreboard: sampled 2ns after the falling edge, predicts the coming rising edge
  always begin
    bit occ, rdy_exp;
    @(negedge aclk);
    #2;
    if (areset) begin
      checks++;
      if (s_tready !== 1'b1 || m_tvalid !== 1'b0) begin
        errors++;
        $display("FAIL reset_hold s_tready=%b m_tvalid=%b required 1/0", s_tready, m_tvalid);
      end
      exp_q.delete();
      model_reset();
    end else begin
      occ = exp_q.size() > 0;
      rdy_exp = !occ || m_tready;
      checks++;
      if (m_tvalid !== occ) begin
        errors++;
        $display("FAIL dpath_valid got %b required %b", m_tvalid, occ);
      end else if (occ) begin
        checks++;
        if ({m_tdata, m_tlast, m_tkeep} !== exp_q[0]) begin
          errors++;
          $display("FAIL dpath_beat got %h required %h", {m_tdata, m_tlast, m_tkeep}, exp_q[0]);
        end
      end
      checks++;
      if (s_tready !== rdy_exp) begin
        errors++;
        $display("FAIL s_tready got %b required %b", s_tready, rdy_exp);
      end
      if (occ && m_tready) void'(exp_q.pop_front());
      if (s_tvalid && rdy_exp) begin
        exp_q.push_back({s_tdata, s_tlast, s_tkeep});
        model_accept(s_tdata, s_tlast, s_tkeep);
      end
      if (clr) model_clear();
    end
  end

  function automatic logic next_ready();
    case (ready_mode)
      1: begin tog = ~tog; return tog; end
      2: return 1'($urandom_range(0, 1));
      3: return 1'b0;
      default: return 1'b1;
    endcase
  endfunction

  // driver tasks
  task automatic idle(input logic c);
    @(negedge aclk);
    s_tvalid = 1'b0; s_tdata = $urandom; s_tlast = 1'($urandom_range(0, 1)); s_tkeep = 4'($urandom);
    clr = c;
    m_tready = next_ready();
  endtask

  task automatic drive_beat(input logic [31:0] d, input logic l, input logic [3:0] k, input logic c);
    int n = 0;
    @(negedge aclk);
    s_tvalid = 1'b1; s_tdata = d; s_tlast = l; s_tkeep = k; clr = c;
    m_tready = next_ready();
    #1;
    while (s_tready !== 1'b1 && n < 50) begin
      @(negedge aclk);
      clr = 1'b0;
      m_tready = next_ready();
      #1;
      n++;
    end
    if (s_tready !== 1'b1) begin
      checks++; errors++;
      $display("FAIL accept_timeout got s_tready=%b required 1 within 50 cycles", s_tready);
    end
  endtask

  task automatic send_clean_frame(input int gap_max);
    for (int i = 0; i < WORDS; i++) begin
      drive_beat({24'hAAAAAA, 8'(i)}, i == WORDS - 1, 4'hF, 1'b0);
      if (gap_max > 0) repeat ($urandom_range(0, gap_max)) idle(1'b0);
    end
  endtask

  task automatic settle();
    ready_mode = 0;
    repeat (3) idle(1'b0);
    #3;
  endtask

  // tests
  task automatic test_reset();
    repeat (2) @(negedge aclk);
    #1;
    checks++;
    if ({m_tvalid, m_tdata, m_tlast, m_tkeep} !== 38'd0) begin
      errors++; $display("FAIL reset_mport got %h required 0", {m_tvalid, m_tdata, m_tlast, m_tkeep});
    end
    checks++;
    if ({frame_cnt, err_cnt, err, lost} !== 66'd0) begin
      errors++; $display("FAIL reset_status got fc=%0d ec=%0d err=%b lost=%b required 0", frame_cnt, err_cnt, err, lost);
    end
    checks++;
    if ({first_err_data, first_err_idx} !== 40'd0) begin
      errors++; $display("FAIL reset_first_err got %h/%h required 0", first_err_data, first_err_idx);
    end
    @(negedge aclk);
    areset = 1'b0;
  endtask

  task automatic test_clean_frames();
    ready_mode = 0;
    repeat (4) send_clean_frame(0);
    settle();
    checks++;
    if (frame_cnt !== 32'd4 || frame_cnt !== md_frame_cnt) begin
      errors++; $display("FAIL clean_frame_cnt got %0d required 4 (model %0d)", frame_cnt, md_frame_cnt);
    end
    checks++;
    if (err_cnt !== 32'd0 || err !== 1'b0) begin
      errors++; $display("FAIL clean_errors got ec=%0d err=%b required 0/0", err_cnt, err);
    end
  endtask

  task automatic test_backpressure();
    ready_mode = 1;
    repeat (4) send_clean_frame(1);
    settle();
    checks++;
    if (frame_cnt !== 32'd8 || frame_cnt !== md_frame_cnt) begin
      errors++; $display("FAIL bp_frame_cnt got %0d required 8 (model %0d)", frame_cnt, md_frame_cnt);
    end
    checks++;
    if (err_cnt !== 32'd0) begin
      errors++; $display("FAIL bp_err_cnt got %0d required 0", err_cnt);
    end
  endtask

  task automatic test_bad_data();
    idle(1'b1);
    for (int i = 0; i < WORDS; i++)
      drive_beat(i == 5 ? 32'hAAAAAB05 : {24'hAAAAAA, 8'(i)}, i == WORDS - 1, 4'hF, 1'b0);
    send_clean_frame(0);
    settle();
    checks++;
    if (err_cnt !== 32'd1 || err !== 1'b1) begin
      errors++; $display("FAIL bad_err got ec=%0d err=%b required 1/1", err_cnt, err);
    end
    checks++;
    if (frame_cnt !== 32'd1) begin
      errors++; $display("FAIL bad_frame_cnt got %0d required 1", frame_cnt);
    end
    checks++;
    if (first_err_data !== (FE_EN ? 32'hAAAAAB05 : 32'd0) || first_err_idx !== (FE_EN ? 8'd5 : 8'd0)) begin
      errors++; $display("FAIL bad_first_err got %h/%0d required %h/%0d", first_err_data, first_err_idx,
                         FE_EN ? 32'hAAAAAB05 : 32'd0, FE_EN ? 5 : 0);
    end
  endtask

  task automatic test_missing_tlast();
    idle(1'b1);
    for (int i = 0; i < WORDS; i++) drive_beat({24'hAAAAAA, 8'(i)}, 1'b0, 4'hF, 1'b0);
    settle();
    checks++;
    if (lost !== 1'b1 || err_cnt !== 32'd1) begin
      errors++; $display("FAIL miss_lost got lost=%b ec=%0d required 1/1", lost, err_cnt);
    end
    for (int i = 0; i < WORDS; i++) drive_beat($urandom, i == WORDS - 1, 4'($urandom), 1'b0);
    settle();
    checks++;
    if (lost !== 1'b0 || err_cnt !== 32'd1 || frame_cnt !== 32'd0) begin
      errors++; $display("FAIL miss_resync got lost=%b ec=%0d fc=%0d required 0/1/0", lost, err_cnt, frame_cnt);
    end
    send_clean_frame(0);
    settle();
    checks++;
    if (frame_cnt !== 32'd1 || frame_cnt !== md_frame_cnt) begin
      errors++; $display("FAIL miss_recover got fc=%0d required 1", frame_cnt);
    end
  endtask

  task automatic test_early_tlast();
    idle(1'b1);
    for (int i = 0; i < 8; i++) drive_beat({24'hAAAAAA, 8'(i)}, i == 7, 4'hF, 1'b0);
    settle();
    checks++;
    if (err_cnt !== 32'd1 || lost !== 1'b0) begin
      errors++; $display("FAIL early_err got ec=%0d lost=%b required 1/0", err_cnt, lost);
    end
    send_clean_frame(0);
    settle();
    checks++;
    if (frame_cnt !== 32'd1 || err_cnt !== 32'd1) begin
      errors++; $display("FAIL early_next got fc=%0d ec=%0d required 1/1", frame_cnt, err_cnt);
    end
  endtask

  task automatic test_clr_and_reset();
    idle(1'b1);
    for (int i = 0; i < 3; i++) drive_beat({24'hAAAAAA, 8'(i)}, 1'b0, 4'hF, 1'b0);
    drive_beat(32'hAAAAAA77, 1'b0, 4'hF, 1'b1);
    for (int i = 4; i < 7; i++) drive_beat({24'hAAAAAA, 8'(i)}, 1'b0, 4'hF, 1'b0);
    settle();
    checks++;
    if ({frame_cnt, err_cnt, err} !== 65'd0 || {first_err_data, first_err_idx} !== 40'd0) begin
      errors++; $display("FAIL clr_wins got fc=%0d ec=%0d err=%b fe=%h required 0", frame_cnt, err_cnt, err, first_err_data);
    end
    ready_mode = 3;
    drive_beat(32'hAAAAAA07, 1'b0, 4'hF, 1'b0);
    idle(1'b0);
    @(negedge aclk);
    areset = 1'b1; s_tvalid = 1'b0;
    #1;
    checks++;
    if (m_tvalid !== 1'b0 || s_tready !== 1'b1) begin
      errors++; $display("FAIL midreset got m_tvalid=%b s_tready=%b required 0/1", m_tvalid, s_tready);
    end
    @(negedge aclk);
    areset = 1'b0; ready_mode = 0;
    send_clean_frame(0);
    settle();
    checks++;
    if (frame_cnt !== 32'd1 || err_cnt !== 32'd0 || lost !== 1'b0) begin
      errors++; $display("FAIL post_reset got fc=%0d ec=%0d lost=%b required 1/0/0", frame_cnt, err_cnt, lost);
    end
  endtask

  task automatic test_random();
    idle(1'b1);
    ready_mode = 2;
    for (int f = 0; f < 12; f++) begin
      for (int i = 0; i < WORDS; i++) begin
        logic [31:0] d = {24'hAAAAAA, 8'(i)};
        logic        l = (i == WORDS - 1);
        logic [3:0]  k = 4'hF;
        logic        c = 1'b0;
        case ($urandom_range(0, 24))
          0: d[20] = ~d[20];
          1: d[7:0] = d[7:0] + 8'd1;
          2: k = 4'h7;
          3: l = ~l;
          4: c = 1'b1;
          default: ;
        endcase
        drive_beat(d, l, k, c);
        repeat ($urandom_range(0, 1)) idle(1'b0);
      end
    end
    settle();
    checks++;
    if (frame_cnt !== md_frame_cnt || err_cnt !== md_err_cnt) begin
      errors++; $display("FAIL rand_counts got fc=%0d ec=%0d required %0d/%0d", frame_cnt, err_cnt, md_frame_cnt, md_err_cnt);
    end
    checks++;
    if (err !== md_err || lost !== !md_synced) begin
      errors++; $display("FAIL rand_flags got err=%b lost=%b required %b/%b", err, lost, md_err, !md_synced);
    end
    checks++;
    if (first_err_data !== (FE_EN ? md_fed : 32'd0) || first_err_idx !== (FE_EN ? md_fei : 8'd0)) begin
      errors++; $display("FAIL rand_first_err got %h/%0d required %h/%0d", first_err_data, first_err_idx,
                         FE_EN ? md_fed : 32'd0, FE_EN ? md_fei : 8'd0);
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_clean_frames();
    test_backpressure();
    test_bad_data();
    test_missing_tlast();
    test_early_tlast();
    test_clr_and_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got no finish required finish before 500000ns");
    $fatal(1, "watchdog expired");
  end

endmodule
